// File: rtl/key_event_detector.sv
// ---------------------------------------------------------------------------
// key_event_detector
//
// Turns a debounced, active-low key level into discrete key events: a press
// pulse, a release pulse, a long-press pulse once the key has been held for
// LONG_PRESS_CYCLES, and periodic auto-repeat pulses while it stays held.
// A running count of accepted presses is kept as well.
//
// Every output is taken straight from a flop, so an event sampled at one
// rising edge becomes visible in the cycle that follows that edge.
//
// Parameters
//   LONG_PRESS_CYCLES : cycles of continuous press before long_press (>= 2)
//   REPEAT_CYCLES     : cycles between auto-repeat pulses (>= 1)
//   COUNT_WIDTH       : width of press_count (>= 1), wraps silently
//
// Ports
//   clock         : single clock, rising edge active
//   reset         : asynchronous, active-high reset
//   key_n         : debounced key level, 0 = pressed, 1 = released
//   press_pulse   : one-cycle pulse per accepted press
//   release_pulse : one-cycle pulse per release of an accepted press
//   long_press    : one-cycle pulse when a press reaches LONG_PRESS_CYCLES
//   repeat_pulse  : one-cycle auto-repeat pulse during a long press
//   held          : level, high while a press is in progress
//   press_count   : running count of accepted presses
// ---------------------------------------------------------------------------
module key_event_detector #(
   parameter int LONG_PRESS_CYCLES = 25000000,
   parameter int REPEAT_CYCLES     = 5000000,
   parameter int COUNT_WIDTH       = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   key_n,
   output logic                   press_pulse,
   output logic                   release_pulse,
   output logic                   long_press,
   output logic                   repeat_pulse,
   output logic                   held,
   output logic [COUNT_WIDTH-1:0] press_count
);

   // The hold timer has to be able to hold LONG_PRESS_CYCLES itself and the
   // repeat timer REPEAT_CYCLES, so neither can wrap while it is counting.
   localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
   localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

   // The hold timer is cleared on the press edge and reaches N at the N-th
   // following low sample, so the long press fires on the sample that sees
   // the timer at LONG_PRESS_CYCLES-1. The repeat timer works the same way
   // relative to the long-press edge.
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

   // ARM is entered from reset and waits for the key to be seen released,
   // so a key that was held through reset never produces an event.
   typedef enum logic [1:0] {
      ARM       = 2'd0,
      IDLE      = 2'd1,
      PRESSED   = 2'd2,
      LONG_HELD = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [HOLD_W-1:0]      hold_q, hold_d;
   logic [REP_W-1:0]       rep_q, rep_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   press_q, press_d;
   logic                   release_q, release_d;
   logic                   long_q, long_d;
   logic                   repeat_q, repeat_d;
   logic                   held_q, held_d;

   // Next-state and next-output logic. Each state gives priority to a
   // release over the timers, which is what suppresses a long press or a
   // repeat that would land on the same edge as the release and keeps the
   // event pulses mutually exclusive.
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      rep_d     = rep_q;
      count_d   = count_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;

      case (state_q)
         ARM: begin
            if (key_n) begin
               state_d = IDLE;
            end
         end

         IDLE: begin
            if (!key_n) begin
               state_d = PRESSED;
               press_d = 1'b1;
               hold_d  = '0;
               count_d = count_q + COUNT_WIDTH'(1);
            end
         end

         PRESSED: begin
            if (key_n) begin
               state_d   = IDLE;
               release_d = 1'b1;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
               if (hold_q == HOLD_LAST) begin
                  state_d = LONG_HELD;
                  long_d  = 1'b1;
                  rep_d   = '0;
               end
            end
         end

         LONG_HELD: begin
            if (key_n) begin
               state_d   = IDLE;
               release_d = 1'b1;
            end else if (rep_q == REP_LAST) begin
               repeat_d = 1'b1;
               rep_d    = '0;
            end else begin
               rep_d = rep_q + REP_W'(1);
            end
         end

         default: begin
            state_d = ARM;
         end
      endcase

      held_d = (state_d == PRESSED) || (state_d == LONG_HELD);
   end

   // State, timers, counter and registered outputs. Reset clears
   // everything immediately, aborting a press in progress without a
   // release pulse and sending the machine back to ARM.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ARM;
         hold_q    <= '0;
         rep_q     <= '0;
         count_q   <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         rep_q     <= rep_d;
         count_q   <= count_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         repeat_q  <= repeat_d;
         held_q    <= held_d;
      end
   end

   // Outputs come straight from the flops.
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign long_press    = long_q;
   assign repeat_pulse  = repeat_q;
   assign held          = held_q;
   assign press_count   = count_q;

endmodule

// File: tb/tb_key_event_detector.sv
// ---------------------------------------------------------------------------
// tb_key_event_detector
//
// Bench for key_event_detector with LONG_PRESS_CYCLES=4, REPEAT_CYCLES=2,
// COUNT_WIDTH=2. A behavioural model tracks how many edges the current press
// has lasted and derives every expected output from that elapsed count; a
// compare process checks the DUT against it on every falling edge. Directed
// scenarios additionally pin pulse positions and counts to literal values.
// ---------------------------------------------------------------------------
module tb_key_event_detector;

   localparam int LONG_CYC = 4;
   localparam int REP_CYC  = 2;
   localparam int CW       = 2;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          key_n = 1'b1;
   logic          pressPulse;
   logic          releasePulse;
   logic          longPress;
   logic          repeatPulse;
   logic          held;
   logic [CW-1:0] pressCount;

   int vectors     = 0;
   int miscompares = 0;
   bit checkOn     = 1'b0;

   // Model state: phase 0 = waiting for release after reset,
   // 1 = idle, 2 = key held; run = edges elapsed since the press edge.
   int mPhase   = 0;
   int mRun     = 0;
   int mCount   = 0;
   bit mPress   = 1'b0;
   bit mRelease = 1'b0;
   bit mLong    = 1'b0;
   bit mRepeat  = 1'b0;
   bit mHeld    = 1'b0;

   key_event_detector #(
      .LONG_PRESS_CYCLES(LONG_CYC),
      .REPEAT_CYCLES(REP_CYC),
      .COUNT_WIDTH(CW)
   ) dut (
      .clock(clock),
      .reset(reset),
      .key_n(key_n),
      .press_pulse(pressPulse),
      .release_pulse(releasePulse),
      .long_press(longPress),
      .repeat_pulse(repeatPulse),
      .held(held),
      .press_count(pressCount)
   );

   always #5 clock = ~clock;

   // Reference model: outputs after an edge follow from the key level
   // sampled at that edge and the number of edges the press has lasted.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mPhase   = 0;
         mRun     = 0;
         mCount   = 0;
         mPress   = 1'b0;
         mRelease = 1'b0;
         mLong    = 1'b0;
         mRepeat  = 1'b0;
         mHeld    = 1'b0;
      end else begin
         mPress   = 1'b0;
         mRelease = 1'b0;
         mLong    = 1'b0;
         mRepeat  = 1'b0;
         if (mPhase == 0) begin
            if (key_n) mPhase = 1;
         end else if (mPhase == 1) begin
            if (!key_n) begin
               mPhase = 2;
               mRun   = 0;
               mPress = 1'b1;
               mCount = (mCount + 1) % (1 << CW);
            end
         end else begin
            if (key_n) begin
               mPhase   = 1;
               mRelease = 1'b1;
            end else begin
               mRun = mRun + 1;
               if (mRun == LONG_CYC) mLong = 1'b1;
               else if (mRun > LONG_CYC && ((mRun - LONG_CYC) % REP_CYC) == 0) mRepeat = 1'b1;
            end
         end
         mHeld = (mPhase == 2);
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors = vectors + 1;
      if (actual != expected) begin
         miscompares = miscompares + 1;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clock) begin
      if (checkOn) begin
         checkOutput("press_pulse", int'(pressPulse), int'(mPress));
         checkOutput("release_pulse", int'(releasePulse), int'(mRelease));
         checkOutput("long_press", int'(longPress), int'(mLong));
         checkOutput("repeat_pulse", int'(repeatPulse), int'(mRepeat));
         checkOutput("held", int'(held), int'(mHeld));
         checkOutput("press_count", int'(pressCount), mCount);
         checkOutput("pulse_exclusive",
                     int'($countones({pressPulse, releasePulse, longPress, repeatPulse}) <= 1), 1);
      end
   end

   // Drive one key level for the next edge and return just after that edge.
   task automatic applyStimulus(input logic level);
      key_n = level;
      @(posedge clock);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_press"}, int'(pressPulse), 0);
      checkOutput({tag, "_release"}, int'(releasePulse), 0);
      checkOutput({tag, "_long"}, int'(longPress), 0);
      checkOutput({tag, "_repeat"}, int'(repeatPulse), 0);
      checkOutput({tag, "_held"}, int'(held), 0);
      checkOutput({tag, "_count"}, int'(pressCount), 0);
   endtask

   // Reset mid-cycle with the given key level, check outputs at once,
   // then release reset just after a later edge.
   task automatic doReset(input logic keyLevel);
      key_n = keyLevel;
      #2;
      reset = 1'b1;
      #1;
      checkAllZero("reset");
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // Hold the key low for lowN edges then release for one edge, recording
   // at which edge (relative to the press edge) each output was high.
   task automatic runPress(input int lowN, output int pm, output int rm,
                           output int lm, output int tm, output int hm);
      pm = 0; rm = 0; lm = 0; tm = 0; hm = 0;
      for (int i = 0; i <= lowN; i++) begin
         applyStimulus((i < lowN) ? 1'b0 : 1'b1);
         pm = pm | (int'(pressPulse) << i);
         rm = rm | (int'(releasePulse) << i);
         lm = lm | (int'(longPress) << i);
         tm = tm | (int'(repeatPulse) << i);
         hm = hm | (int'(held) << i);
      end
      applyStimulus(1'b1);
   endtask

   initial begin
      int pm, rm, lm, tm, hm;
      int anyOut;
      int wrapExp [5];
      logic level;
      int len;

      wrapExp[0] = 1; wrapExp[1] = 2; wrapExp[2] = 3; wrapExp[3] = 0; wrapExp[4] = 1;

      checkOn = 1'b1;
      doReset(1'b1);
      applyStimulus(1'b1);
      applyStimulus(1'b1);

      // Short press: three low edges, release on the fourth.
      runPress(3, pm, rm, lm, tm, hm);
      checkOutput("short_press_at", pm, 1);
      checkOutput("short_release_at", rm, 8);
      checkOutput("short_held_at", hm, 7);
      checkOutput("short_long_none", lm, 0);
      checkOutput("short_count", int'(pressCount), 1);

      // Count wrap with one-cycle presses.
      doReset(1'b1);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      for (int n = 0; n < 5; n++) begin
         runPress(1, pm, rm, lm, tm, hm);
         checkOutput("blip_press_at", pm, 1);
         checkOutput("blip_release_at", rm, 2);
         checkOutput("wrap_count", int'(pressCount), wrapExp[n]);
      end

      // Long press with auto-repeat.
      runPress(10, pm, rm, lm, tm, hm);
      checkOutput("long_press_at", pm, 1);
      checkOutput("long_long_at", lm, 16);
      checkOutput("long_repeat_at", tm, 32'h140);
      checkOutput("long_release_at", rm, 32'h400);

      // Release on the edge where long_press would have fired.
      runPress(4, pm, rm, lm, tm, hm);
      checkOutput("coinc_long_none", lm, 0);
      checkOutput("coinc_release_at", rm, 16);

      // Key held through reset is never counted.
      doReset(1'b0);
      anyOut = 0;
      for (int i = 0; i < 9; i++) begin
         applyStimulus((i < 8) ? 1'b0 : 1'b1);
         anyOut = anyOut | int'(pressPulse | releasePulse | longPress | repeatPulse | held);
      end
      checkOutput("hold_thru_reset_quiet", anyOut, 0);
      checkOutput("hold_thru_reset_count", int'(pressCount), 0);
      runPress(2, pm, rm, lm, tm, hm);
      checkOutput("after_hold_count", int'(pressCount), 1);

      // Reset in the middle of a press.
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      #2;
      reset = 1'b1;
      #1;
      checkAllZero("midpress");
      @(posedge clock);
      #1;
      reset = 1'b0;
      anyOut = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus((i < 3) ? 1'b0 : 1'b1);
         anyOut = anyOut | int'(pressPulse | releasePulse | longPress | repeatPulse | held);
      end
      checkOutput("midpress_quiet", anyOut, 0);
      runPress(1, pm, rm, lm, tm, hm);
      checkOutput("midpress_next_press", pm, 1);
      checkOutput("midpress_next_count", int'(pressCount), 1);

      // Randomised key activity with occasional asynchronous resets.
      level = 1'b1;
      for (int b = 0; b < 220; b++) begin
         level = ~level;
         len = $urandom_range(1, 12);
         for (int c = 0; c < len; c++) begin
            applyStimulus(level);
            if ($urandom_range(0, 149) == 0) begin
               #1;
               reset = 1'b1;
               #2;
               reset = 1'b0;
            end
         end
      end

      applyStimulus(1'b1);
      applyStimulus(1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/key_event_detector.md
KEY_EVENT_DETECTOR -- requirements
Module: key_event_detector

Interface
REQ-001 Parameter LONG_PRESS_CYCLES, 25000000, clock cycles a key must stay pressed before long_press fires; legal range >= 2.
REQ-002 Parameter REPEAT_CYCLES, 5000000, clock cycles between auto-repeat pulses after long_press; legal range >= 1.
REQ-003 Parameter COUNT_WIDTH, 8, width of press_count; legal range >= 1.
REQ-004 Port clock, input, 1, single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1, asynchronous, active-high reset.
REQ-006 Port key_n, input, 1, debounced key level from the upstream debounce stage; 0 = pressed, 1 = released.
REQ-007 Port press_pulse, output, 1, one-cycle pulse on each accepted press.
REQ-008 Port release_pulse, output, 1, one-cycle pulse on each release after an accepted press.
REQ-009 Port long_press, output, 1, one-cycle pulse when a press reaches LONG_PRESS_CYCLES.
REQ-010 Port repeat_pulse, output, 1, one-cycle auto-repeat pulse while a long press continues.
REQ-011 Port held, output, 1, level; 1 while the FSM is in PRESSED or LONG_HELD.
REQ-012 Port press_count, output, COUNT_WIDTH, running count of accepted presses.

Function
REQ-013 The FSM SHALL have four states: ARM, IDLE, PRESSED and LONG_HELD.
REQ-014 All outputs SHALL be registered; a condition sampled at rising edge k SHALL appear on the outputs in the cycle after edge k (1-cycle latency).
REQ-015 ARM: if key_n is sampled 1, the FSM SHALL go to IDLE; if key_n is sampled 0, it SHALL stay in ARM with no pulses, so a key held through reset is never counted.
REQ-016 IDLE: if key_n is sampled 0 at edge k, the FSM SHALL go to PRESSED, assert press_pulse for one cycle, clear the hold timer and increment press_count.
REQ-017 press_count SHALL wrap modulo 2^COUNT_WIDTH (all-ones + 1 -> 0) with no flag.
REQ-018 PRESSED: the hold timer SHALL increment at each edge where key_n is sampled 0.
REQ-019 If key_n is sampled 0 at every edge k..k+LONG_PRESS_CYCLES, then at edge k+LONG_PRESS_CYCLES the FSM SHALL go to LONG_HELD, pulse long_press for one cycle and clear the repeat timer.
REQ-020 LONG_HELD: repeat_pulse SHALL pulse at edges k+LONG_PRESS_CYCLES+j*REPEAT_CYCLES, j = 1, 2, ..., while key_n stays sampled 0.
REQ-021 PRESSED or LONG_HELD: if key_n is sampled 1 at edge m, the FSM SHALL go to IDLE and pulse release_pulse for one cycle.
REQ-022 If a release coincides with the edge at which long_press or repeat_pulse would fire, only release_pulse SHALL fire.
REQ-023 A press and a release SHALL each be recognised within one cycle; a 1-cycle low on key_n SHALL yield press_pulse followed immediately by release_pulse.
REQ-024 At most one of press_pulse, release_pulse, long_press and repeat_pulse SHALL be high in any cycle.
REQ-025 Timer widths SHALL be at least $clog2(LONG_PRESS_CYCLES+1) and $clog2(REPEAT_CYCLES+1); the timers SHALL never wrap while in use.

Reset
REQ-026 While reset is high, the FSM SHALL be in ARM, the timers and press_count SHALL be 0, and all pulses and held SHALL be 0, independent of clock.
REQ-027 Reset asserted mid-press SHALL abort the press without release_pulse; after reset deasserts, the key must be sampled released (ARM -> IDLE) before a new press is accepted.

Verification (LONG_PRESS_CYCLES=4, REPEAT_CYCLES=2, COUNT_WIDTH=2)
REQ-028 Short press: key_n low for edges 10..12, high at 13 -> press_pulse after edge 10, held 1 after edges 10..12, release_pulse after edge 13, press_count=1, no long_press.
REQ-029 Long press with repeat: key_n low for edges 10..19, high at 20 -> press_pulse @10, long_press @14, repeat_pulse @16 and @18, release_pulse @20.
REQ-030 Coincident release: key_n low for edges 10..13, high at 14 -> release_pulse @14, no long_press at any time.
REQ-031 Count wrap: 5 separated presses -> press_count reads 1,2,3,0,1.
REQ-032 Held through reset: key_n=0 while reset deasserts, then held 8 cycles and released -> no pulses, held stays 0, press_count=0; the next press counts as 1.
REQ-033 Mid-press reset: reset asserted asynchronously between edges 12 and 13 of a press started at 10 -> all outputs 0 immediately, no release_pulse, FSM returns to ARM.
